// File: rtl/control_sequencer.sv
// control_sequencer: micro-op sequencer for the SAP-style 8-bit CPU.
// Walks T-states T0..T(NUM_T-1) and decodes opcode x stage into the
// 15-bit control word. It supports early end of short instructions, a stall
// input, a sticky HALT stage and instruction-boundary strobes.
module control_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int NUM_T     = 6,
    parameter int STAGE_W   = 3,
    parameter int EARLY_END = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                step_en,
    output logic [14:0]         ctrl,
    output logic [STAGE_W-1:0]  stage,
    output logic                halted,
    output logic                instr_start,
    output logic                instr_done
);

    // Bit map 14..0: C_P,E_P,L_P,/L_MA,/L_MD,/CE,/L_R,/L_I,/E_I,/L_A,E_A,S_U,E_U,/L_B,/L_O
    localparam logic [14:0] IDLE_WORD = 15'h0FE3;

    localparam logic [STAGE_W-1:0] ST_T0   = STAGE_W'(0);
    localparam logic [STAGE_W-1:0] ST_T1   = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] ST_T2   = STAGE_W'(2);
    localparam logic [STAGE_W-1:0] ST_T3   = STAGE_W'(3);
    localparam logic [STAGE_W-1:0] ST_T4   = STAGE_W'(4);
    localparam logic [STAGE_W-1:0] ST_T5   = STAGE_W'(5);
    localparam logic [STAGE_W-1:0] ST_LAST = STAGE_W'(NUM_T - 1);
    localparam logic [STAGE_W-1:0] ST_IDLE = STAGE_W'(NUM_T);
    localparam logic [STAGE_W-1:0] ST_HALT = STAGE_W'(NUM_T + 1);

    typedef enum logic [3:0] {
        OP_HLT = 4'd0,
        OP_NOP = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_LDA = 4'd4,
        OP_OUT = 4'd5,
        OP_STA = 4'd6,
        OP_JMP = 4'd7
    } op_e;

    logic [STAGE_W-1:0] stage_q;
    logic [STAGE_W-1:0] stage_d;
    op_e                op;
    logic [STAGE_W-1:0] last_used;
    logic               is_final;
    logic [14:0]        word;

    // Opcode classification: wide or undefined opcodes behave as NOP.
    always_comb begin
        op = OP_NOP;
        if (((opcode >> 4) == '0) && (opcode[3] == 1'b0)) begin
            op = op_e'(opcode[3:0]);
        end
    end

    // Last stage each instruction needs, and whether the current stage ends it.
    always_comb begin
        case (op)
            OP_HLT, OP_OUT, OP_JMP: last_used = ST_T3;
            OP_LDA, OP_STA:         last_used = ST_T4;
            OP_ADD, OP_SUB:         last_used = ST_T5;
            default:                last_used = ST_T2;
        endcase
        if (EARLY_END != 0) begin
            is_final = (stage_q == last_used);
        end else begin
            is_final = (stage_q == ST_LAST);
        end
    end

    // Control word for the current T-state (fetch, then per-opcode execute).
    always_comb begin
        word = IDLE_WORD;
        if (stage_q == ST_T0) begin
            word = 15'h27E3;
        end else if (stage_q == ST_T1) begin
            word = 15'h4FE3;
        end else if (stage_q == ST_T2) begin
            word = 15'h0D63;
        end else begin
            case (op)
                OP_LDA: begin
                    if (stage_q == ST_T3)      word = 15'h07A3;
                    else if (stage_q == ST_T4) word = 15'h0DC3;
                end
                OP_ADD: begin
                    if (stage_q == ST_T3)      word = 15'h07A3;
                    else if (stage_q == ST_T4) word = 15'h0DE1;
                    else if (stage_q == ST_T5) word = 15'h0FC7;
                end
                OP_SUB: begin
                    if (stage_q == ST_T3)      word = 15'h07A3;
                    else if (stage_q == ST_T4) word = 15'h0DE1;
                    else if (stage_q == ST_T5) word = 15'h0FCF;
                end
                OP_STA: begin
                    if (stage_q == ST_T3)      word = 15'h07A3;
                    else if (stage_q == ST_T4) word = 15'h0EF3;
                end
                OP_OUT: begin
                    if (stage_q == ST_T3)      word = 15'h0FF2;
                end
                OP_JMP: begin
                    if (stage_q == ST_T3)      word = 15'h1FA3;
                end
                default: word = IDLE_WORD;
            endcase
        end
    end

    // Next-stage and output decode; stalls emit IDLE_WORD so no load/increment repeats.
    always_comb begin
        stage_d     = stage_q;
        ctrl        = IDLE_WORD;
        halted      = 1'b0;
        instr_start = 1'b0;
        instr_done  = 1'b0;
        if (stage_q == ST_HALT) begin
            halted = 1'b1;
        end else if (stage_q == ST_IDLE) begin
            if (step_en) begin
                stage_d = ST_T0;
            end
        end else if (stage_q < ST_IDLE) begin
            if (step_en) begin
                ctrl        = word;
                instr_start = (stage_q == ST_T0);
                if ((op == OP_HLT) && (stage_q == ST_T3)) begin
                    instr_done = 1'b1;
                    stage_d    = ST_HALT;
                end else if (is_final) begin
                    instr_done = 1'b1;
                    stage_d    = ST_T0;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
        end else begin
            stage_d = ST_IDLE;
        end
    end

    // Stage register; reset parks the sequencer in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= ST_IDLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage = stage_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer.
// One instance uses early end, a second runs every instruction to T5.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        step_en;

    logic [14:0] ctrl;
    logic [2:0]  stage;
    logic        halted, instr_start, instr_done;

    logic [14:0] ctrl0;
    logic [2:0]  stage0;
    logic        halted0, instr_start0, instr_done0;

    int unsigned vectors;
    int unsigned miscompares;

    logic [14:0] exp_w [6][3];
    int unsigned last_t [6];
    logic [3:0]  op_tab [6];

    control_sequencer #(.OPCODE_W(4), .NUM_T(6), .STAGE_W(3), .EARLY_END(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .step_en(step_en),
        .ctrl(ctrl), .stage(stage), .halted(halted),
        .instr_start(instr_start), .instr_done(instr_done)
    );

    control_sequencer #(.OPCODE_W(4), .NUM_T(6), .STAGE_W(3), .EARLY_END(0)) dut_full (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .step_en(step_en),
        .ctrl(ctrl0), .stage(stage0), .halted(halted0),
        .instr_start(instr_start0), .instr_done(instr_done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        step_en = 1'b1;
        edge_step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        opcode = 4'd2;
        do_reset();
        vectors++;
        if ({stage, ctrl, halted, instr_start, instr_done} !== {3'd6, 15'h0FE3, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_state got st=%0d ctrl=%h h/s/d=%b%b%b want st=6 ctrl=0fe3 000",
                     stage, ctrl, halted, instr_start, instr_done);
        end
        edge_step();
        vectors++;
        if ({stage, ctrl, instr_start} !== {3'd0, 15'h27E3, 1'b1}) begin
            miscompares++;
            $display("FAIL fetch_T0 got st=%0d ctrl=%h start=%b want st=0 ctrl=27e3 start=1",
                     stage, ctrl, instr_start);
        end
        edge_step();
        vectors++;
        if ({stage, ctrl, instr_start} !== {3'd1, 15'h4FE3, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_T1 got st=%0d ctrl=%h start=%b want st=1 ctrl=4fe3 start=0",
                     stage, ctrl, instr_start);
        end
        edge_step();
        vectors++;
        if ({stage, ctrl, instr_done} !== {3'd2, 15'h0D63, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_T2 got st=%0d ctrl=%h done=%b want st=2 ctrl=0d63 done=0",
                     stage, ctrl, instr_done);
        end
    endtask

    task automatic test_exec();
        op_tab[0] = 4'd4; exp_w[0][0] = 15'h07A3; exp_w[0][1] = 15'h0DC3; exp_w[0][2] = 15'h0FE3; last_t[0] = 4;
        op_tab[1] = 4'd2; exp_w[1][0] = 15'h07A3; exp_w[1][1] = 15'h0DE1; exp_w[1][2] = 15'h0FC7; last_t[1] = 5;
        op_tab[2] = 4'd3; exp_w[2][0] = 15'h07A3; exp_w[2][1] = 15'h0DE1; exp_w[2][2] = 15'h0FCF; last_t[2] = 5;
        op_tab[3] = 4'd6; exp_w[3][0] = 15'h07A3; exp_w[3][1] = 15'h0EF3; exp_w[3][2] = 15'h0FE3; last_t[3] = 4;
        op_tab[4] = 4'd5; exp_w[4][0] = 15'h0FF2; exp_w[4][1] = 15'h0FE3; exp_w[4][2] = 15'h0FE3; last_t[4] = 3;
        op_tab[5] = 4'd7; exp_w[5][0] = 15'h1FA3; exp_w[5][1] = 15'h0FE3; exp_w[5][2] = 15'h0FE3; last_t[5] = 3;
        for (int unsigned i = 0; i < 6; i++) begin
            opcode = op_tab[i];
            do_reset();
            for (int unsigned k = 0; k < 3; k++) edge_step();
            for (int unsigned t = 3; t <= last_t[i]; t++) begin
                edge_step();
                vectors++;
                if ({stage, ctrl, instr_done} !== {3'(t), exp_w[i][t-3], (t == last_t[i])}) begin
                    miscompares++;
                    $display("FAIL exec_op%0d_T%0d got st=%0d ctrl=%h done=%b want ctrl=%h done=%b",
                             op_tab[i], t, stage, ctrl, instr_done, exp_w[i][t-3], (t == last_t[i]));
                end
            end
            edge_step();
            vectors++;
            if ({stage, ctrl, instr_start} !== {3'd0, 15'h27E3, 1'b1}) begin
                miscompares++;
                $display("FAIL back_to_back_op%0d got st=%0d ctrl=%h start=%b want st=0 ctrl=27e3 start=1",
                         op_tab[i], stage, ctrl, instr_start);
            end
        end
    endtask

    task automatic test_out_full();
        opcode = 4'd5;
        do_reset();
        for (int unsigned k = 0; k < 4; k++) edge_step();
        vectors++;
        if ({stage0, ctrl0, instr_done0} !== {3'd3, 15'h0FF2, 1'b0}) begin
            miscompares++;
            $display("FAIL full_out_T3 got st=%0d ctrl=%h done=%b want st=3 ctrl=0ff2 done=0",
                     stage0, ctrl0, instr_done0);
        end
        edge_step();
        vectors++;
        if ({stage0, ctrl0, instr_done0} !== {3'd4, 15'h0FE3, 1'b0}) begin
            miscompares++;
            $display("FAIL full_out_T4 got st=%0d ctrl=%h done=%b want st=4 ctrl=0fe3 done=0",
                     stage0, ctrl0, instr_done0);
        end
        edge_step();
        vectors++;
        if ({stage0, ctrl0, instr_done0} !== {3'd5, 15'h0FE3, 1'b1}) begin
            miscompares++;
            $display("FAIL full_out_T5 got st=%0d ctrl=%h done=%b want st=5 ctrl=0fe3 done=1",
                     stage0, ctrl0, instr_done0);
        end
        edge_step();
        vectors++;
        if (stage0 !== 3'd0) begin
            miscompares++;
            $display("FAIL full_out_wrap got st=%0d want st=0", stage0);
        end
    endtask

    task automatic test_nop();
        opcode = 4'd9;
        do_reset();
        for (int unsigned k = 0; k < 3; k++) edge_step();
        vectors++;
        if ({stage, ctrl, instr_done} !== {3'd2, 15'h0D63, 1'b1}) begin
            miscompares++;
            $display("FAIL undef_T2 got st=%0d ctrl=%h done=%b want st=2 ctrl=0d63 done=1",
                     stage, ctrl, instr_done);
        end
        opcode = 4'd1;
        edge_step();
        vectors++;
        if ({stage, instr_start} !== {3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL undef_wrap got st=%0d start=%b want st=0 start=1", stage, instr_start);
        end
        for (int unsigned k = 0; k < 2; k++) edge_step();
        vectors++;
        if ({stage, instr_done} !== {3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL nop_T2 got st=%0d done=%b want st=2 done=1", stage, instr_done);
        end
    endtask

    task automatic test_stall();
        opcode = 4'd2;
        do_reset();
        edge_step();
        edge_step();
        step_en = 1'b0;
        #1;
        for (int unsigned c = 0; c < 3; c++) begin
            vectors++;
            if ({stage, ctrl, instr_start, instr_done} !== {3'd1, 15'h0FE3, 2'b00}) begin
                miscompares++;
                $display("FAIL stall_cycle%0d got st=%0d ctrl=%h s/d=%b%b want st=1 ctrl=0fe3 00",
                         c, stage, ctrl, instr_start, instr_done);
            end
            if (c < 2) edge_step();
        end
        step_en = 1'b1;
        #1;
        vectors++;
        if ({stage, ctrl} !== {3'd1, 15'h4FE3}) begin
            miscompares++;
            $display("FAIL stall_resume got st=%0d ctrl=%h want st=1 ctrl=4fe3", stage, ctrl);
        end
        edge_step();
        vectors++;
        if ({stage, ctrl} !== {3'd2, 15'h0D63}) begin
            miscompares++;
            $display("FAIL stall_after got st=%0d ctrl=%h want st=2 ctrl=0d63", stage, ctrl);
        end
    endtask

    task automatic test_halt();
        opcode = 4'd0;
        do_reset();
        for (int unsigned k = 0; k < 4; k++) edge_step();
        vectors++;
        if ({stage, ctrl, instr_done} !== {3'd3, 15'h0FE3, 1'b1}) begin
            miscompares++;
            $display("FAIL hlt_T3 got st=%0d ctrl=%h done=%b want st=3 ctrl=0fe3 done=1",
                     stage, ctrl, instr_done);
        end
        edge_step();
        for (int unsigned k = 0; k < 20; k++) begin
            vectors++;
            if ({stage, halted, ctrl, instr_start, instr_done, stage0, halted0, ctrl0}
                    !== {3'd7, 1'b1, 15'h0FE3, 2'b00, 3'd7, 1'b1, 15'h0FE3}) begin
                miscompares++;
                $display("FAIL halt_sticky%0d got st=%0d h=%b ctrl=%h full st=%0d h=%b want st=7 h=1 ctrl=0fe3",
                         k, stage, halted, ctrl, stage0, halted0);
            end
            step_en = ~step_en;
            edge_step();
        end
        step_en = 1'b1;
    endtask

    task automatic test_async_reset();
        opcode = 4'd4;
        do_reset();
        for (int unsigned k = 0; k < 5; k++) edge_step();
        vectors++;
        if ({stage, ctrl} !== {3'd4, 15'h0DC3}) begin
            miscompares++;
            $display("FAIL lda_T4 got st=%0d ctrl=%h want st=4 ctrl=0dc3", stage, ctrl);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({stage, ctrl, halted, instr_done} !== {3'd6, 15'h0FE3, 2'b00}) begin
            miscompares++;
            $display("FAIL async_reset got st=%0d ctrl=%h h/d=%b%b want st=6 ctrl=0fe3 00",
                     stage, ctrl, halted, instr_done);
        end
        edge_step();
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        step_en     = 1'b0;
        opcode      = 4'd0;
        test_reset();
        test_exec();
        test_out_full();
        test_nop();
        test_stall();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
